regfile_port_sched: RTL

//  Owns the single write port (A3/WD3/WE3) of the 32x32 register file. After reset it

---
 rtl/regfile_port_sched.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/regfile_port_sched.sv
// Write-port scheduler for a 32x32 register file.
// After reset it zero-fills r1..r(NREG-1), then shares the single write port
// between the WB stage and a long-latency unit (mul/div/load-miss). The WB
// stage normally has priority. A refused long-latency result is forced
// through once it has waited STARVE_LIMIT cycles. A busy scoreboard of
// pending long-latency destinations drives the decode-stage stall.
module regfile_port_sched #(
    parameter int NREG         = 32,
    parameter int AW           = 5,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_a3,
    input  logic [DW-1:0] wb_wd,
    output logic          wb_stall,
    input  logic          ll_valid,
    input  logic [AW-1:0] ll_a3,
    input  logic [DW-1:0] ll_wd,
    output logic          ll_ready,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_a3,
    input  logic [AW-1:0] id_a1,
    input  logic [AW-1:0] id_a2,
    output logic          stall_id,
    output logic [AW-1:0] a3,
    output logic [DW-1:0] wd3,
    output logic          we3,
    output logic          init_done
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   clr_ptr_reg;
    logic [SW-1:0]   starve_reg;
    logic [NREG-1:0] busy_reg;

    logic run;
    logic forced;
    logic ll_ready_run;
    logic wb_stall_run;
    logic ll_grant;
    logic wb_grant;

    // A reset applied in the middle of RUN takes effect combinationally on the
    // outputs, so RUN-only behaviour is gated by the live reset input as well.
    assign run          = (state_reg == ST_RUN) && !rst;
    assign forced       = (starve_reg == SW'(STARVE_LIMIT));
    assign ll_ready_run = !wb_we || forced;
    assign wb_stall_run = wb_we && forced && ll_valid;
    assign ll_grant     = run && ll_valid && ll_ready_run;
    assign wb_grant     = run && wb_we && !wb_stall_run && !ll_grant;

    // State register: reset always restarts the zero-fill.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_CLEAR;
        else     state_reg <= state_next;
    end

    // Next state: leave CLEAR after the last register has been written.
    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_CLEAR && clr_ptr_reg == AW'(NREG - 1))
            state_next = ST_RUN;
    end

    // Zero-fill pointer: starts at r1, because r0 is hardwired zero.
    always_ff @(posedge clk) begin
        if (rst)                        clr_ptr_reg <= AW'(1);
        else if (state_reg == ST_CLEAR) clr_ptr_reg <= clr_ptr_reg + AW'(1);
    end

    // Starvation counter: counts consecutive refused LL cycles and saturates.
    // It clears after a transfer, or when the LL unit has nothing to offer.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_reg <= '0;
        end else if (run && ll_valid && !ll_ready_run) begin
            if (!forced) starve_reg <= starve_reg + SW'(1);
        end else begin
            starve_reg <= '0;
        end
    end

    // Busy scoreboard: an issue sets the bit and an LL transfer clears it.
    // When both hit the same register, the issue wins. r0 is never busy.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_reg[gi] = 1'b0;
            end else begin : g_bit
                // Per-register pending flag.
                always_ff @(posedge clk) begin
                    if (rst)
                        busy_reg[gi] <= 1'b0;
                    else if (run && issue_valid && issue_a3 == AW'(gi))
                        busy_reg[gi] <= 1'b1;
                    else if (ll_grant && ll_a3 == AW'(gi))
                        busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Outputs: write port, handshakes and stalls, from state plus live inputs.
    // A granted write to r0 completes its handshake but writes nothing.
    always_comb begin
        we3       = 1'b0;
        a3        = '0;
        wd3       = '0;
        ll_ready  = 1'b0;
        wb_stall  = 1'b1;
        stall_id  = 1'b1;
        init_done = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_CLEAR: begin
                    we3 = 1'b1;
                    a3  = clr_ptr_reg;
                end
                default: begin
                    init_done = 1'b1;
                    ll_ready  = ll_ready_run;
                    wb_stall  = wb_stall_run;
                    stall_id  = busy_reg[id_a1] | busy_reg[id_a2];
                    if (ll_grant && ll_a3 != '0) begin
                        we3 = 1'b1;
                        a3  = ll_a3;
                        wd3 = ll_wd;
                    end else if (wb_grant && wb_a3 != '0) begin
                        we3 = 1'b1;
                        a3  = wb_a3;
                        wd3 = wb_wd;
                    end
                end
            endcase
        end
    end

endmodule
